// File: rtl/frame_max_acc.sv
// frame_max_acc: per-frame running max, first index of the max, and sum over a valid/ready sample stream; result valid 1 cycle after last sample.
// in_ready only in COLLECT, result held in HOLD until out_ready; optional TRACK_MIN_EN adds min_val/min_idx.
module frame_max_acc #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       frame_len,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       max_val,
  output logic [CNT_W-1:0]       max_idx,
  output logic [WIDTH+CNT_W-1:0] sum_val,
  output logic                   busy
`ifdef TRACK_MIN_EN
  ,
  output logic [WIDTH-1:0]       min_val,
  output logic [CNT_W-1:0]       min_idx
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;
  logic             start_acc;
  logic             xfer;
  logic             last_xfer;
  logic             first_xfer;

  assign start_acc  = (state == IDLE) && start && (frame_len != '0);
  assign xfer       = in_valid && in_ready;
  assign first_xfer = (cnt == '0);
  assign last_xfer  = xfer && (cnt == (len - CNT_ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc) state_nxt = COLLECT;
      COLLECT: if (last_xfer) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode the registered state, so they never glitch on inputs.
  always_comb begin
    in_ready  = (state == COLLECT);
    out_valid = (state == HOLD);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len     <= '0;
      cnt     <= '0;
      max_val <= '0;
      max_idx <= '0;
      sum_val <= '0;
    end else if (start_acc) begin
      len     <= frame_len;
      cnt     <= '0;
      max_val <= '0;
      max_idx <= '0;
      sum_val <= '0;
    end else if (xfer) begin
      sum_val <= sum_val + {{CNT_W{1'b0}}, in_data};
      cnt     <= cnt + CNT_ONE;
      // Strict compare keeps the earliest index on ties.
      if (first_xfer || (in_data > max_val)) begin
        max_val <= in_data;
        max_idx <= cnt;
      end
    end
  end

`ifdef TRACK_MIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_val <= '0;
      min_idx <= '0;
    end else if (start_acc) begin
      min_val <= '0;
      min_idx <= '0;
    end else if (xfer) begin
      if (first_xfer || (in_data < min_val)) begin
        min_val <= in_data;
        min_idx <= cnt;
      end
    end
  end
`endif

endmodule
